key_conditioner: RTL
====================

# key_conditioner

Conditions the board's raw active-low push-buttons into clean, synchronous, active-high control signals for the lab top levels. Each key gets a two-flop synchronizer, a per-key debounce state machine, a debounced level output, one-cycle press/release pulses and optional auto-repeat. The block sits between the KEY pins and the top level's Reset/LoadB/Run logic, so register loads and sum captures happen exactly once per physical press.

## Interface
- N_KEYS, default 4: number of independent key channels.
- DEBOUNCE_CYCLES, default 1_000_000 (20 ms at 50 MHz): consecutive stable synchronized samples required to accept a press or release. Legal values are ≥ 1.
- REPEAT_CYCLES, default 0: auto-repeat period while a key is held. 0 disables auto-repeat. Legal values are 0 or ≥ 2.
- Clk  input  1: 50 MHz system clock; all logic is on its rising edge.
- Reset  input  1: reset, synchronous and active-high. Driven from the board's reset source, not from this block's outputs.
- KEY  input  N_KEYS: raw push-buttons, active-low (0 = pressed), asynchronous to Clk.
- Level  output  N_KEYS: debounced state, active-high (1 = pressed).
- Press  output  N_KEYS: one-cycle pulse on an accepted press, plus one pulse per auto-repeat.
- Release  output  N_KEYS: one-cycle pulse on an accepted release.

## Operation
- Synchronizer: per key, two flops, s1 <= KEY[i] and s2 <= s1. Both reset to 1 (released). The state machine uses s2 only.
- Counter: one per key, width $clog2(max(DEBOUNCE_CYCLES, REPEAT_CYCLES)+1). Reset value is 0.
- State machine per key, states IDLE, PRESS_WAIT, DOWN, RELEASE_WAIT. Reset state is IDLE.
  - IDLE:
    - s2 = 0: go to PRESS_WAIT, count <= 0.
    - s2 = 1: stay.
  - PRESS_WAIT:
    - s2 = 1: go to IDLE, count <= 0 (bounce rejected, no pulse).
    - s2 = 0 and count = DEBOUNCE_CYCLES-1: go to DOWN, Level <= 1, Press <= 1, count <= 0.
    - s2 = 0 otherwise: count++.
  - DOWN:
    - s2 = 1: go to RELEASE_WAIT, count <= 0. This takes priority over repeat.
    - s2 = 0 and REPEAT_CYCLES ≠ 0 and count = REPEAT_CYCLES-1: Press <= 1, count <= 0.
    - s2 = 0 and REPEAT_CYCLES ≠ 0 otherwise: count++.
    - s2 = 0 and REPEAT_CYCLES = 0: count holds at 0.
  - RELEASE_WAIT:
    - s2 = 0: go back to DOWN, count <= 0. Level stays 1 and no Press pulse is issued (release bounce).
    - s2 = 1 and count = DEBOUNCE_CYCLES-1: go to IDLE, Level <= 0, Release <= 1.
    - s2 = 1 otherwise: count++.
- Press and Release default to 0 every cycle; they are high only in the cycle after a qualifying edge.
- Press and Release are never high together on one key.
- Channels are fully independent. Simultaneous activity on several keys yields simultaneous pulses.

## Timing
- All outputs are registered.
- Reset values: Level = 0, Press = 0, Release = 0, every state IDLE, every counter 0, synchronizer flops 1.
- Reset asserted mid-operation (any state, any count) returns the channel to the reset values at the next edge, with no Release pulse. A key still held after Reset deasserts re-qualifies as a fresh press: Press fires DEBOUNCE_CYCLES+2 edges after the first post-reset edge that samples KEY low.
- Press latency: if KEY is first sampled low at edge 0 and stays low, PRESS_WAIT is entered at edge 2. Press and Level rise at edge DEBOUNCE_CYCLES+2.
- Release latency: symmetric. Release pulses and Level falls at edge DEBOUNCE_CYCLES+2 after KEY is first sampled high.
- Rejected glitch length: a low pulse shorter than DEBOUNCE_CYCLES+1 sampled cycles produces no output activity.
- Auto-repeat: the first repeat Press comes REPEAT_CYCLES edges after the initial Press, then one every REPEAT_CYCLES edges while held.
- A bounce during RELEASE_WAIT restarts the repeat phase from 0.

## Test plan
Parameters for all scenarios: N_KEYS=4, DEBOUNCE_CYCLES=4, REPEAT_CYCLES=0 unless stated.
- Reset: hold Reset 3 cycles with KEY=4'b0000 -> Level=0, Press=0, Release=0 throughout. After deassert, Press=4'b1111 for exactly one cycle at edge 6 after the first low sample.
- Clean press/release: KEY[1] low at edge 0 for 20 cycles, then high -> Press[1] high only in the cycle after edge 6, Level[1] high from edge 6, Release[1] pulses at edge 26, Level[1] low from edge 26.
- Bounce rejection: KEY[0] low 3 cycles, high 1, low 2, high -> Level, Press and Release all stay 0.
- Release bounce: hold KEY[2] until Level[2]=1, then high 2 cycles, low 1, high steady -> exactly one Release[2] and no extra Press[2]. Release[2] comes DEBOUNCE_CYCLES+2 edges after the final high sample.
- Auto-repeat (REPEAT_CYCLES=5): hold KEY[3] low 30 cycles -> Press[3] at edges 6, 11, 16, 21, 26, 31, with Level[3] steady at 1.
- Reset mid-hold: assert Reset while Level[0]=1 -> Level[0]=0 next edge with no Release pulse. If KEY[0] is still held, Press[0] fires again 6 edges after the first post-reset low sample.

Source files
------------

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - synchronize, debounce and edge-pulse active-low push-buttons
module key_conditioner #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_CYCLES   = 0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [N_KEYS-1:0] KEY,
    output logic [N_KEYS-1:0] Level,
    output logic [N_KEYS-1:0] Press,
    output logic [N_KEYS-1:0] Release
);

    localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam bit REPEAT_EN  = (REPEAT_CYCLES != 0);

    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST = REPEAT_EN ? CW'(REPEAT_CYCLES - 1) : '0;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        DOWN,
        RELEASE_WAIT
    } key_state_t;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        logic          s1;
        logic          s2;
        key_state_t    state;
        key_state_t    state_nxt;
        logic [CW-1:0] count;
        logic [CW-1:0] count_nxt;
        logic          level_q;
        logic          level_nxt;
        logic          press_q;
        logic          press_nxt;
        logic          release_q;
        logic          release_nxt;

        always_ff @(posedge Clk) begin
            if (Reset) begin
                s1        <= 1'b1;
                s2        <= 1'b1;
                state     <= IDLE;
                count     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                s1        <= KEY[i];
                s2        <= s1;
                state     <= state_nxt;
                count     <= count_nxt;
                level_q   <= level_nxt;
                press_q   <= press_nxt;
                release_q <= release_nxt;
            end
        end

        // s2 is the synchronized key: 0 means the button is held down
        always_comb begin
            state_nxt   = state;
            count_nxt   = count;
            level_nxt   = level_q;
            press_nxt   = 1'b0;
            release_nxt = 1'b0;
            unique case (state)
                IDLE: begin
                    if (!s2) begin
                        state_nxt = PRESS_WAIT;
                        count_nxt = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (s2) begin
                        state_nxt = IDLE;
                        count_nxt = '0;
                    end else if (count == DEB_LAST) begin
                        state_nxt = DOWN;
                        level_nxt = 1'b1;
                        press_nxt = 1'b1;
                        count_nxt = '0;
                    end else begin
                        count_nxt = count + CNT_ONE;
                    end
                end
                DOWN: begin
                    if (s2) begin
                        state_nxt = RELEASE_WAIT;
                        count_nxt = '0;
                    end else if (REPEAT_EN) begin
                        if (count == REP_LAST) begin
                            press_nxt = 1'b1;
                            count_nxt = '0;
                        end else begin
                            count_nxt = count + CNT_ONE;
                        end
                    end else begin
                        count_nxt = '0;
                    end
                end
                RELEASE_WAIT: begin
                    // a low sample here is release bounce: back to DOWN, repeat phase restarts
                    if (!s2) begin
                        state_nxt = DOWN;
                        count_nxt = '0;
                    end else if (count == DEB_LAST) begin
                        state_nxt   = IDLE;
                        level_nxt   = 1'b0;
                        release_nxt = 1'b1;
                        count_nxt   = '0;
                    end else begin
                        count_nxt = count + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end
            endcase
        end

        assign Level[i]   = level_q;
        assign Press[i]   = press_q;
        assign Release[i] = release_q;
    end

endmodule
